gesture_score_sequencer: RTL

- Sequences one full classification pass over the voxel-bin memory.
- Sweeps the cell address across all NUM_CLASSES weight ROMs and the voxel count buffer in lockstep, and multiply-accumulates one signed score per class.
- After the sweep, selects the winning class and reports it against a programmable minimum score.
- Sits between the voxel binning stage (count buffer) and the gesture output/UART logic; it is the sole address master for the per-class weight ROMs.

---
 rtl/gesture_score_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/gesture_score_sequencer.sv
// gesture_score_sequencer
// Runs one classification pass over the voxel-bin memory. It sweeps a shared
// cell address across the per-class weight ROMs and the voxel count buffer,
// multiply-accumulates one signed score per class, then selects the
// highest-scoring class and qualifies it against a programmable minimum.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle pass request, honoured only when idle
//   abort          cancel the pass in progress, no result produced
//   min_score      signed threshold for gesture_valid, sampled in ARGMAX
//   cell_addr      shared read address to weight ROMs and count buffer
//   rd_en          cell_addr is valid this cycle
//   weight_in      ROM outputs, class k at [k*WEIGHT_BITS +: WEIGHT_BITS]
//   count_in       voxel count, same one-cycle latency as the ROMs
//   busy           pass in progress (also freezes count buffer writes)
//   result_valid   one-cycle pulse when a new result is registered
//   gesture_class  winning class index
//   gesture_valid  best_score > min_score
//   best_score     winning accumulated score
module gesture_score_sequencer #(
  parameter int unsigned NUM_CELLS   = 1024,
  parameter int unsigned NUM_CLASSES = 4,
  parameter int unsigned WEIGHT_BITS = 8,
  parameter int unsigned COUNT_BITS  = 8,
  parameter int unsigned ACC_BITS    = 28
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic signed [ACC_BITS-1:0]           min_score,
  output logic [$clog2(NUM_CELLS)-1:0]         cell_addr,
  output logic                                 rd_en,
  input  logic [NUM_CLASSES*WEIGHT_BITS-1:0]   weight_in,
  input  logic [COUNT_BITS-1:0]                count_in,
  output logic                                 busy,
  output logic                                 result_valid,
  output logic [$clog2(NUM_CLASSES)-1:0]       gesture_class,
  output logic                                 gesture_valid,
  output logic signed [ACC_BITS-1:0]           best_score
);

  localparam int unsigned ADDR_W = $clog2(NUM_CELLS);
  localparam int unsigned CLS_W  = $clog2(NUM_CLASSES);
  localparam int unsigned PROD_W = WEIGHT_BITS + COUNT_BITS + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWEEP  = 2'd1,
    S_DRAIN  = 2'd2,
    S_ARGMAX = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic clear_acc;
  logic addr_load;
  logic addr_inc;
  logic do_result;

  // Read data arriving this cycle belongs to an address issued last cycle.
  logic data_vld_q;
  logic acc_en;

  logic signed [ACC_BITS-1:0] acc_q [NUM_CLASSES];
  logic signed [PROD_W-1:0]   prod  [NUM_CLASSES];

  logic [CLS_W-1:0]           win_idx;
  logic signed [ACC_BITS-1:0] win_val;
  logic                       win_ok;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes
  always_comb begin
    state_d   = state_q;
    clear_acc = 1'b0;
    addr_load = 1'b0;
    addr_inc  = 1'b0;
    do_result = 1'b0;
    case (state_q)
      S_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          state_d   = S_SWEEP;
          clear_acc = 1'b1;
          addr_load = 1'b1;
        end
      end
      S_SWEEP: begin
        if (abort)                       state_d = S_IDLE;
        else if (cell_addr == LAST_ADDR) state_d = S_DRAIN;
        else                             addr_inc = 1'b1;
      end
      S_DRAIN: begin
        state_d = abort ? S_IDLE : S_ARGMAX;
      end
      S_ARGMAX: begin
        state_d   = S_IDLE;
        do_result = !abort;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered address/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_addr  <= '0;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      data_vld_q <= 1'b0;
    end else begin
      if (addr_load)     cell_addr <= '0;
      else if (addr_inc) cell_addr <= cell_addr + ADDR_W'(1);
      rd_en      <= (state_d == S_SWEEP);
      busy       <= (state_d != S_IDLE);
      data_vld_q <= rd_en;
    end
  end

  // signed weight x zero-extended count; both operands widened to PROD_W first
  always_comb begin
    for (int k = 0; k < int'(NUM_CLASSES); k++) begin
      logic signed [PROD_W-1:0] w_ext;
      logic signed [PROD_W-1:0] c_ext;
      w_ext   = PROD_W'($signed(weight_in[k*WEIGHT_BITS +: WEIGHT_BITS]));
      c_ext   = $signed(PROD_W'(count_in));
      prod[k] = w_ext * c_ext;
    end
  end

  // Only accumulate while a pass is live, so data from an aborted read is dropped.
  assign acc_en = data_vld_q && ((state_q == S_SWEEP) || (state_q == S_DRAIN));

  // Per-class accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_CLASSES); k++) acc_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_CLASSES); k++) begin
        if (clear_acc)   acc_q[k] <= '0;
        else if (acc_en) acc_q[k] <= acc_q[k] + ACC_BITS'(prod[k]);
      end
    end
  end

  // Strict greater-than scan from class 0 so ties keep the lowest index.
  always_comb begin
    win_idx = '0;
    win_val = acc_q[0];
    for (int k = 1; k < int'(NUM_CLASSES); k++) begin
      if (acc_q[k] > win_val) begin
        win_idx = CLS_W'(k);
        win_val = acc_q[k];
      end
    end
    win_ok = (win_val > min_score);
  end

  // Result registers hold until the next result or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid  <= 1'b0;
      gesture_class <= '0;
      gesture_valid <= 1'b0;
      best_score    <= '0;
    end else begin
      result_valid <= do_result;
      if (do_result) begin
        gesture_class <= win_idx;
        gesture_valid <= win_ok;
        best_score    <= win_val;
      end
    end
  end

endmodule
